numlock_button_conditioner: RTL and testbench
=============================================

// Module: numlock_button_conditioner
// PURPOSE
// - Front end of the number lock. Conditions the two raw pushbuttons (U = "1", Z = "0") before the lock FSM sees them.
// - Each channel is synchronized, then debounced. The result is a clean level (U/Z) plus a one-clock press pulse (U_pulse/Z_pulse).
// - The lock FSM consumes U and Z directly. It relies on one clean 0->1->0 per physical press.
// PARAMETERS
// - DEBOUNCE_CYCLES  500000  consecutive stable synced samples required (5 ms @ 100 MHz); must be >= 2. TB uses 4.
// - CNT_W            19      counter width; must satisfy 2**CNT_W >= DEBOUNCE_CYCLES.
// PORTS
// - clk       in   1  system clock; all state updates on the rising edge.
// - reset     in   1  asynchronous, active-high; clears every flop.
// - BtnU_raw  in   1  raw "1" button, asynchronous and bouncy.
// - BtnZ_raw  in   1  raw "0" button, asynchronous and bouncy.
// - U         out  1  debounced level of BtnU; feeds the lock's U input.
// - Z         out  1  debounced level of BtnZ; feeds the lock's Z input.
// - U_pulse   out  1  high exactly 1 clk when U's debounced press is accepted.
// - Z_pulse   out  1  high exactly 1 clk when Z's debounced press is accepted.
// - U_state   out  2  channel U FSM state, for debug/LEDs.
// - Z_state   out  2  channel Z FSM state, for debug/LEDs.
// BEHAVIOUR
// - Reset: sync flops = 0, both FSMs = IDLE, counters = 0, U = Z = U_pulse = Z_pulse = 0.
// - Sync: raw -> ff1 -> ff2 = btn_s. btn_s reflects raw after 2 edges. No logic sits between ff1 and ff2.
// - Channels are fully independent. Simultaneous presses are conditioned separately; no interlock here.
// - Per-channel FSM (2-bit code), registered outputs:
//   - IDLE(00): level=0.
//     - btn_s=1 -> cnt<=0, go PRESS_WAIT.
//   - PRESS_WAIT(01): level=0.
//     - btn_s=0 -> IDLE (bounce rejected).
//     - Else if cnt==DEBOUNCE_CYCLES-1 -> PRESSED, pulse<=1.
//     - Else cnt<=cnt+1.
//   - PRESSED(10): level=1.
//     - btn_s=0 -> cnt<=0, go RELEASE_WAIT.
//   - RELEASE_WAIT(11): level=1.
//     - btn_s=1 -> PRESSED, with no new pulse.
//     - Else if cnt==DEBOUNCE_CYCLES-1 -> IDLE.
//     - Else cnt<=cnt+1.
// - level = state in {PRESSED, RELEASE_WAIT}, registered. pulse is registered and cleared the following cycle.
// - Press latency: raw sampled high at edge 1 and held stable -> level and pulse rise after edge DEBOUNCE_CYCLES+3 (edge 7 for D=4).
// - Release latency: raw stable low from edge 1 -> level falls after edge DEBOUNCE_CYCLES+3.
// - A glitch shorter than DEBOUNCE_CYCLES synced cycles never changes level or produces a pulse.
// - Any btn_s change while waiting restarts the qualification, via the IDLE or PRESSED transition.
// - Counter never wraps. It is bounded by the DEBOUNCE_CYCLES-1 compare and reset on every wait entry.
// - Illegal state cannot occur with 2-bit full encoding. Every code is defined.
// - Reset mid-operation: immediate return to reset values. A held button must be fully re-debounced after release of reset, and then yields one pulse.
// STRUCTURE
// - Shared package/include (numlock_pkg): localparams DB_IDLE=2'b00, DB_PRESS_WAIT=2'b01, DB_PRESSED=2'b10, DB_RELEASE_WAIT=2'b11.
// - Sub-module numlock_debounce_ch: synchronizer + counter + FSM for one button. Ports clk, reset, raw, level, pulse, state. Parameters are passed through.
// - Top instantiates numlock_debounce_ch twice (U, Z). No other logic at top.
// TESTING (DEBOUNCE_CYCLES=4)
// 1. Assert reset with both raw = 1 -> all outputs 0 during reset; both states 00.
// 2. Clean press: BtnU_raw 0->1 before edge 1, held 20 cycles -> U=1 after edge 7; U_pulse=1 for edge 7 only; U_state=10.
// 3. Press bounce: BtnU_raw 1,0,1,0,1 on successive cycles, then held -> exactly one U_pulse, 7 edges after the final 0->1 sample.
// 4. Release bounce: in PRESSED, raw low for 2 cycles then high -> U stays 1; state 11 then 10; no second pulse.
// 5. Clean release plus reset: raw low -> U falls 7 edges later. Repeat the press, assert reset during PRESS_WAIT with raw held high -> all 0, then the pulse arrives 7 edges after reset release.
// 6. Both buttons pressed 2 cycles apart -> U_pulse and Z_pulse each fire once, 2 cycles apart; levels are independent.

Source files
------------

// File: rtl/numlock_pkg.sv
// numlock_pkg: shared state codes for the number-lock button conditioner.
package numlock_pkg;
  localparam logic [1:0] DB_IDLE         = 2'b00;
  localparam logic [1:0] DB_PRESS_WAIT   = 2'b01;
  localparam logic [1:0] DB_PRESSED      = 2'b10;
  localparam logic [1:0] DB_RELEASE_WAIT = 2'b11;
endpackage

// File: rtl/numlock_debounce_ch.sv
// numlock_debounce_ch: two-flop synchronizer plus counting debounce FSM for one button.
module numlock_debounce_ch
  import numlock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       raw,
  output logic       level,
  output logic       pulse,
  output logic [1:0] state
);
  logic             ff1;
  logic             btn_s;
  logic [1:0]       next;
  logic [CNT_W-1:0] cnt;
  logic             done;
  assign done = cnt == CNT_W'(DEBOUNCE_CYCLES - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ff1   <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      ff1   <= raw;
      btn_s <= ff1;
    end
  // The counter only runs while staying in a wait state, so every wait entry starts from zero.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= DB_IDLE;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      state <= next;
      cnt   <= (state[0] && next == state) ? cnt + 1'b1 : '0;
      pulse <= state == DB_PRESS_WAIT && btn_s && done;
    end
  always_comb begin
    next = state;
    case (state)
      DB_IDLE:       next = btn_s ? DB_PRESS_WAIT : DB_IDLE;
      DB_PRESS_WAIT: next = !btn_s ? DB_IDLE : done ? DB_PRESSED : DB_PRESS_WAIT;
      DB_PRESSED:    next = btn_s ? DB_PRESSED : DB_RELEASE_WAIT;
      default:       next = btn_s ? DB_PRESSED : done ? DB_IDLE : DB_RELEASE_WAIT;
    endcase
  end
  always_comb level = state[1];
endmodule

// File: rtl/numlock_button_conditioner.sv
// numlock_button_conditioner: independent debounced "1" (U) and "0" (Z) button channels.
module numlock_button_conditioner
  import numlock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       BtnU_raw,
  input  logic       BtnZ_raw,
  output logic       U,
  output logic       Z,
  output logic       U_pulse,
  output logic       Z_pulse,
  output logic [1:0] U_state,
  output logic [1:0] Z_state
);
  numlock_debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_ch (
    .clk(clk), .reset(reset), .raw(BtnU_raw), .level(U), .pulse(U_pulse), .state(U_state)
  );
  numlock_debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) z_ch (
    .clk(clk), .reset(reset), .raw(BtnZ_raw), .level(Z), .pulse(Z_pulse), .state(Z_state)
  );
endmodule

// File: tb/tb_numlock_button_conditioner.sv
// tb_numlock_button_conditioner: randomized and directed checks against a run-length debounce model.
module tb_numlock_button_conditioner;
  localparam int D = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic BtnU_raw = 1'b0;
  logic BtnZ_raw = 1'b0;
  logic U, Z, U_pulse, Z_pulse;
  logic [1:0] U_state, Z_state;
  int checks = 0;
  int errors = 0;
  numlock_button_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .BtnU_raw(BtnU_raw), .BtnZ_raw(BtnZ_raw),
    .U(U), .Z(Z), .U_pulse(U_pulse), .Z_pulse(Z_pulse), .U_state(U_state), .Z_state(Z_state)
  );
  always #5 clk = ~clk;
  wire [7:0] obs = {U, Z, U_pulse, Z_pulse, U_state, Z_state};
  // Model: a channel's level flips once the synced input has disagreed with it for D+1 straight samples.
  logic [1:0] m_d1, m_d2, m_lvl, m_pul;
  int m_run[2];
  function automatic logic [7:0] expv();
    return {m_lvl[0], m_lvl[1], m_pul[0], m_pul[1],
            m_lvl[0], m_run[0] != 0, m_lvl[1], m_run[1] != 0};
  endfunction
  task automatic model_clear();
    m_d1 = '0; m_d2 = '0; m_lvl = '0; m_pul = '0; m_run[0] = 0; m_run[1] = 0;
  endtask
  task automatic tick();
    @(posedge clk);
    if (reset) model_clear();
    else begin
      for (int c = 0; c < 2; c++) begin
        m_pul[c] = 1'b0;
        m_run[c] = (m_d2[c] != m_lvl[c]) ? m_run[c] + 1 : 0;
        if (m_run[c] == D + 1) begin
          m_lvl[c] = m_d2[c];
          m_pul[c] = m_d2[c];
          m_run[c] = 0;
        end
      end
      m_d2 = m_d1;
      m_d1 = {BtnZ_raw, BtnU_raw};
    end
    @(negedge clk);
  endtask
  task automatic test_reset();
    reset = 1'b1; BtnU_raw = 1'b1; BtnZ_raw = 1'b1;
    model_clear();
    for (int e = 0; e < 4; e++) begin
      tick();
      if (obs !== 8'h00) begin errors++; $display("FAIL reset cycle %0d got %h want 00", e, obs); end
      checks++;
    end
    BtnU_raw = 1'b0; BtnZ_raw = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick(); tick();
  endtask
  task automatic test_clean_press();
    int first = 0, cnt = 0;
    BtnU_raw = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (obs !== expv()) begin errors++; $display("FAIL clean_press edge %0d got %h want %h", e, obs, expv()); end
      checks++;
      if (U_pulse) begin cnt++; if (first == 0) first = e; end
    end
    if (first !== D + 3) begin errors++; $display("FAIL clean_press_latency got %0d want %0d", first, D + 3); end
    checks++;
    if (cnt !== 1) begin errors++; $display("FAIL clean_press_pulses got %0d want 1", cnt); end
    checks++;
    if (U_state !== 2'b10 || U !== 1'b1) begin errors++; $display("FAIL clean_press_state got %b/%b want 10/1", U_state, U); end
    checks++;
  endtask
  task automatic test_press_bounce();
    logic [4:0] pat = 5'b10101;
    int first = 0, cnt = 0;
    BtnU_raw = 1'b0;
    for (int e = 0; e < 12; e++) tick();
    for (int e = 1; e <= 20; e++) begin
      BtnU_raw = e <= 5 ? pat[e-1] : 1'b1;
      tick();
      if (obs !== expv()) begin errors++; $display("FAIL press_bounce edge %0d got %h want %h", e, obs, expv()); end
      checks++;
      if (U_pulse) begin cnt++; if (first == 0) first = e; end
    end
    if (first !== 5 + D + 2) begin errors++; $display("FAIL press_bounce_latency got %0d want %0d", first, 5 + D + 2); end
    checks++;
    if (cnt !== 1) begin errors++; $display("FAIL press_bounce_pulses got %0d want 1", cnt); end
    checks++;
  endtask
  task automatic test_release_bounce();
    logic [1:0] st[1:12];
    int cnt = 0, low = 0;
    for (int e = 1; e <= 12; e++) begin
      BtnU_raw = e >= 3;
      tick();
      st[e] = U_state;
      if (obs !== expv()) begin errors++; $display("FAIL release_bounce edge %0d got %h want %h", e, obs, expv()); end
      checks++;
      if (U_pulse) cnt++;
      if (!U) low++;
    end
    if ({st[3], st[4], st[5]} !== 6'b111110) begin
      errors++; $display("FAIL release_bounce_states got %b %b %b want 11 11 10", st[3], st[4], st[5]);
    end
    checks++;
    if (cnt !== 0 || low !== 0) begin errors++; $display("FAIL release_bounce_level pulses %0d low %0d want 0 0", cnt, low); end
    checks++;
  endtask
  task automatic test_release_reset();
    int fall = 0, first = 0;
    BtnU_raw = 1'b0;
    for (int e = 1; e <= 15; e++) begin
      tick();
      if (obs !== expv()) begin errors++; $display("FAIL release edge %0d got %h want %h", e, obs, expv()); end
      checks++;
      if (!U && fall == 0) fall = e;
    end
    if (fall !== D + 3) begin errors++; $display("FAIL release_latency got %0d want %0d", fall, D + 3); end
    checks++;
    BtnU_raw = 1'b1;
    for (int e = 0; e < 4; e++) tick();
    if (U_state !== 2'b01) begin errors++; $display("FAIL press_wait_state got %b want 01", U_state); end
    checks++;
    reset = 1'b1;
    #1;
    model_clear();
    if (obs !== 8'h00) begin errors++; $display("FAIL async_reset got %h want 00", obs); end
    checks++;
    tick(); tick();
    reset = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (obs !== expv()) begin errors++; $display("FAIL post_reset edge %0d got %h want %h", e, obs, expv()); end
      checks++;
      if (U_pulse && first == 0) first = e;
    end
    if (first !== D + 3) begin errors++; $display("FAIL post_reset_latency got %0d want %0d", first, D + 3); end
    checks++;
  endtask
  task automatic test_both();
    int pu = 0, pz = 0, cu = 0, cz = 0;
    BtnU_raw = 1'b0; BtnZ_raw = 1'b0;
    for (int e = 0; e < 12; e++) tick();
    for (int e = 1; e <= 20; e++) begin
      BtnU_raw = 1'b1;
      BtnZ_raw = e >= 3;
      tick();
      if (obs !== expv()) begin errors++; $display("FAIL both edge %0d got %h want %h", e, obs, expv()); end
      checks++;
      if (U_pulse) begin cu++; if (pu == 0) pu = e; end
      if (Z_pulse) begin cz++; if (pz == 0) pz = e; end
      if (e == 8 && (U !== 1'b1 || Z !== 1'b0)) begin errors++; $display("FAIL both_levels got U=%b Z=%b want 1 0", U, Z); end
      if (e == 8) checks++;
    end
    if (pu !== D + 3 || pz !== D + 5 || cu !== 1 || cz !== 1) begin
      errors++; $display("FAIL both_pulses got edges %0d %0d counts %0d %0d want %0d %0d 1 1", pu, pz, cu, cz, D + 3, D + 5);
    end
    checks++;
  endtask
  task automatic test_random();
    int hold[2] = '{0, 0};
    for (int e = 1; e <= 600; e++) begin
      for (int c = 0; c < 2; c++) begin
        if (hold[c] == 0) begin
          hold[c] = $urandom_range(1, 8);
          if (c == 0) BtnU_raw = $urandom_range(0, 1) == 1;
          else BtnZ_raw = $urandom_range(0, 1) == 1;
        end
        hold[c]--;
      end
      tick();
      if (obs !== expv()) begin errors++; $display("FAIL random edge %0d got %h want %h", e, obs, expv()); end
      checks++;
    end
  endtask
  initial begin
    test_reset();
    test_clean_press();
    test_press_bounce();
    test_release_bounce();
    test_release_reset();
    test_both();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
